vga_text_render: RTL and testbench

Text-mode pixel renderer directly downstream of the VGA sync generator. Consumes the generator's pixel position, activevideo and sync outputs on the pixel clock. Looks up a character code in an external synchronous character RAM, then a glyph row in an external synchronous font ROM, and emits a 3-bit RGB pixel with hsync/vsync re-aligned to the pixel pipeline. Adds a frame-counted blinking block cursor.

---
 rtl/vga_text_render.sv | 143 ++++++++++++++
 tb/tb_vga_text_render.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_render.sv
// Text-mode pixel renderer: char RAM -> font ROM lookup with a blinking block cursor.
// Fixed 4-clock latency from pixel position to rgb/de/hsync/vsync.
module vga_text_render #(
    parameter int COLS      = 80,
    parameter int ROWS      = 30,
    parameter int CHAR_W    = 8,
    parameter int CHAR_H    = 16,
    parameter int VRAM_AW   = 12,
    parameter int BLINK_BIT = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               activevideo_in,
    input  logic [10:0]        x_px,
    input  logic [10:0]        y_px,
    output logic [VRAM_AW-1:0] vram_addr,
    input  logic [7:0]         vram_data,
    output logic [11:0]        font_addr,
    input  logic [7:0]         font_data,
    input  logic [2:0]         fg_color,
    input  logic [2:0]         bg_color,
    input  logic               cursor_en,
    input  logic [6:0]         cursor_col,
    input  logic [4:0]         cursor_row,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               de_out,
    output logic [2:0]         rgb
);

    localparam logic [7:0] COLS_L = 8'(COLS);
    localparam logic [6:0] ROWS_L = 7'(ROWS);

    logic [7:0]         col;
    logic [6:0]         row;

    logic [VRAM_AW-1:0] vram_addr_d, vram_addr_q;
    logic [11:0]        font_addr_d, font_addr_q;

    logic               vld_p1_d, vld_p1_q, vld_p2_q, vld_p3_q, vld_p4_q;
    logic [2:0]         bit_sel_p1_d, bit_sel_p1_q, bit_sel_p2_q, bit_sel_p3_q, bit_sel_p4_q;
    logic               cur_p1_d, cur_p1_q, cur_p2_q, cur_p3_q, cur_p4_q;
    logic [3:0]         glyph_row_p1_d, glyph_row_p1_q, glyph_row_p2_q;

    logic [4:0]         hs_pipe_d, hs_pipe_q;
    logic [4:0]         vs_pipe_d, vs_pipe_q;

    logic               vs_prev_d, vs_prev_q;
    logic [5:0]         frame_cnt_d, frame_cnt_q;

    logic               pix;
    logic               de_d, de_q;
    logic [2:0]         rgb_d, rgb_q;

    always_comb begin
        col = 8'(x_px >> $clog2(CHAR_W));
        row = 7'(y_px >> $clog2(CHAR_H));

        // S1: cell address and per-pixel sidebands
        vram_addr_d    = VRAM_AW'(int'(row) * COLS + int'(col));
        vld_p1_d       = activevideo_in && (col < COLS_L) && (row < ROWS_L);
        bit_sel_p1_d   = x_px[2:0];
        glyph_row_p1_d = y_px[3:0];
        cur_p1_d       = cursor_en && (col == {1'b0, cursor_col}) && (row == {2'b00, cursor_row});

        // S3: character code from RAM joins the glyph row
        font_addr_d = {vram_data, glyph_row_p2_q};

        // Output: glyph bit, cursor inversion during the blink-on phase
        pix   = font_data[3'd7 - bit_sel_p4_q] ^ (cur_p4_q & frame_cnt_q[BLINK_BIT]);
        de_d  = vld_p4_q;
        rgb_d = vld_p4_q ? (pix ? fg_color : bg_color) : 3'b000;

        hs_pipe_d = {hs_pipe_q[3:0], hsync_in};
        vs_pipe_d = {vs_pipe_q[3:0], vsync_in};

        vs_prev_d   = vsync_in;
        frame_cnt_d = frame_cnt_q;
        if (vs_prev_q && !vsync_in) begin
            frame_cnt_d = frame_cnt_q + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vram_addr_q    <= '0;
            font_addr_q    <= '0;
            vld_p1_q       <= 1'b0;
            vld_p2_q       <= 1'b0;
            vld_p3_q       <= 1'b0;
            vld_p4_q       <= 1'b0;
            bit_sel_p1_q   <= '0;
            bit_sel_p2_q   <= '0;
            bit_sel_p3_q   <= '0;
            bit_sel_p4_q   <= '0;
            cur_p1_q       <= 1'b0;
            cur_p2_q       <= 1'b0;
            cur_p3_q       <= 1'b0;
            cur_p4_q       <= 1'b0;
            glyph_row_p1_q <= '0;
            glyph_row_p2_q <= '0;
            hs_pipe_q      <= '1;
            vs_pipe_q      <= '1;
            vs_prev_q      <= 1'b1;
            frame_cnt_q    <= '0;
            de_q           <= 1'b0;
            rgb_q          <= '0;
        end else begin
            vram_addr_q    <= vram_addr_d;
            font_addr_q    <= font_addr_d;
            vld_p1_q       <= vld_p1_d;
            vld_p2_q       <= vld_p1_q;
            vld_p3_q       <= vld_p2_q;
            vld_p4_q       <= vld_p3_q;
            bit_sel_p1_q   <= bit_sel_p1_d;
            bit_sel_p2_q   <= bit_sel_p1_q;
            bit_sel_p3_q   <= bit_sel_p2_q;
            bit_sel_p4_q   <= bit_sel_p3_q;
            cur_p1_q       <= cur_p1_d;
            cur_p2_q       <= cur_p1_q;
            cur_p3_q       <= cur_p2_q;
            cur_p4_q       <= cur_p3_q;
            glyph_row_p1_q <= glyph_row_p1_d;
            glyph_row_p2_q <= glyph_row_p1_q;
            hs_pipe_q      <= hs_pipe_d;
            vs_pipe_q      <= vs_pipe_d;
            vs_prev_q      <= vs_prev_d;
            frame_cnt_q    <= frame_cnt_d;
            de_q           <= de_d;
            rgb_q          <= rgb_d;
        end
    end

    assign vram_addr = vram_addr_q;
    assign font_addr = font_addr_q;
    assign hsync_out = hs_pipe_q[4];
    assign vsync_out = vs_pipe_q[4];
    assign de_out    = de_q;
    assign rgb       = rgb_q;

endmodule

// File: tb/tb_vga_text_render.sv
// Bench for vga_text_render: synchronous RAM/ROM models plus a per-sample reference
// model that predicts every output from the pixel-position rules.
module tb_vga_text_render;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsync_in, vsync_in, activevideo_in;
    logic [10:0] x_px, y_px;
    logic [11:0] vram_addr;
    logic [7:0]  vram_data;
    logic [11:0] font_addr;
    logic [7:0]  font_data;
    logic [2:0]  fg_color, bg_color;
    logic        cursor_en;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        hsync_out, vsync_out, de_out;
    logic [2:0]  rgb;

    always #5 clk = ~clk;

    vga_text_render dut (
        .clk(clk), .rst_n(rst_n),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .activevideo_in(activevideo_in),
        .x_px(x_px), .y_px(y_px),
        .vram_addr(vram_addr), .vram_data(vram_data),
        .font_addr(font_addr), .font_data(font_data),
        .fg_color(fg_color), .bg_color(bg_color),
        .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out), .rgb(rgb)
    );

    logic [7:0] vram [0:4095];
    logic [7:0] font [0:4095];

    always @(posedge clk) begin
        vram_data <= vram[vram_addr];
        font_data <= font[font_addr];
    end

    typedef struct {
        bit          hs;
        bit          vs;
        bit          de;
        bit          gbit;
        bit          chit;
        logic [11:0] fa;
    } rec_t;

    rec_t        hist [8];
    int          n;
    logic [5:0]  fcnt;
    bit          vsprev;
    int          errors = 0;
    int          checks = 0;

    logic        e_hs, e_vs, e_de;
    logic [2:0]  e_rgb;
    logic [11:0] e_va, e_fa;
    bit          fa_ok;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        n      = 0;
        fcnt   = 6'd0;
        vsprev = 1'b1;
    endtask

    // Called just after an active edge: predicts what that edge produced.
    task automatic model_edge();
        rec_t       r, cur;
        int         col, row, addr;
        logic [7:0] ch, g;
        bit         blink;
        blink = fcnt[5];
        if (n >= 4) begin
            r = hist[(n - 4) & 7];
        end else begin
            r.hs = 1; r.vs = 1; r.de = 0; r.gbit = 0; r.chit = 0; r.fa = '0;
        end
        e_hs  = r.hs;
        e_vs  = r.vs;
        e_de  = r.de;
        e_rgb = !r.de ? 3'b000 : ((r.gbit ^ (r.chit & blink)) ? fg_color : bg_color);
        if (vsprev && !vsync_in) fcnt = fcnt + 6'd1;
        vsprev = vsync_in;

        col  = int'(x_px) / 8;
        row  = int'(y_px) / 16;
        addr = (row * 80 + col) % 4096;
        ch   = vram[addr];
        g    = font[{ch, y_px[3:0]}];
        cur.hs   = hsync_in;
        cur.vs   = vsync_in;
        cur.de   = activevideo_in && col < 80 && row < 30;
        cur.gbit = g[7 - (int'(x_px) % 8)];
        cur.chit = cursor_en && col == int'(cursor_col) && row == int'(cursor_row);
        cur.fa   = {ch, y_px[3:0]};
        e_va  = 12'(addr);
        fa_ok = (n >= 2);
        if (fa_ok) e_fa = hist[(n - 2) & 7].fa;
        hist[n & 7] = cur;
        n++;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("rgb", 16'(rgb), 16'(e_rgb));
        chk("de_out", 16'(de_out), 16'(e_de));
        chk("hsync_out", 16'(hsync_out), 16'(e_hs));
        chk("vsync_out", 16'(vsync_out), 16'(e_vs));
        chk("vram_addr", 16'(vram_addr), 16'(e_va));
        if (fa_ok) chk("font_addr", 16'(font_addr), 16'(e_fa));
    endtask

    task automatic rand_pixel();
        x_px           = 11'($urandom_range(0, 720));
        y_px           = 11'($urandom_range(0, 520));
        activevideo_in = ($urandom_range(0, 7) != 0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_hs"}, 16'(hsync_out), 16'd1);
        chk({tag, "_vs"}, 16'(vsync_out), 16'd1);
        chk({tag, "_rgb"}, 16'(rgb), 16'd0);
        chk({tag, "_de"}, 16'(de_out), 16'd0);
        chk({tag, "_va"}, 16'(vram_addr), 16'd0);
    endtask

    initial begin
        int lowcnt;
        int frames;
        for (int i = 0; i < 4096; i++) begin
            vram[i] = 8'($urandom);
            font[i] = 8'($urandom);
        end
        vram[162] = 8'h41;
        font[12'h413] = 8'h80;
        vram[163] = 8'h00;
        for (int i = 0; i < 16; i++) font[i] = 8'h00;

        rst_n = 1'b0;
        hsync_in = 1'b1; vsync_in = 1'b1; activevideo_in = 1'b0;
        x_px = '0; y_px = '0;
        fg_color = 3'b010; bg_color = 3'b101;
        cursor_en = 1'b0; cursor_col = '0; cursor_row = '0;

        // Reset held while inputs toggle
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rand_pixel();
            hsync_in = 1'($urandom);
            vsync_in = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            check_idle("rst");
            chk("rst_fa", 16'(font_addr), 16'd0);
        end
        hsync_in = 1'b1; vsync_in = 1'b1;
        rst_n = 1'b1;
        model_reset();

        // Directed address/latency example
        x_px = 11'd17; y_px = 11'd35; activevideo_in = 1'b1;
        cycle();
        chk("dir_vram_addr", 16'(vram_addr), 16'd162);
        cycle(); cycle();
        chk("dir_font_addr", 16'(font_addr), 16'h413);
        cycle(); cycle();
        chk("dir_rgb_bg", 16'(rgb), 16'(3'b101));
        x_px = 11'd16;
        for (int i = 0; i < 5; i++) cycle();
        chk("dir_rgb_fg", 16'(rgb), 16'(3'b010));

        // Random pixels, colours and cursor
        for (int i = 0; i < 300; i++) begin
            rand_pixel();
            fg_color   = 3'($urandom_range(0, 7));
            bg_color   = 3'($urandom_range(0, 7));
            cursor_en  = 1'($urandom);
            cursor_col = 7'($urandom_range(0, 127));
            cursor_row = 5'($urandom_range(0, 31));
            cycle();
        end

        // hsync low for 96 clocks
        lowcnt = 0;
        for (int i = 0; i < 110; i++) begin
            rand_pixel();
            hsync_in = !(i < 96);
            cycle();
            if (hsync_out === 1'b0) lowcnt++;
        end
        chk("hs_low_len", 16'(lowcnt), 16'd96);

        // vsync low for two 800-clock lines
        lowcnt = 0;
        for (int i = 0; i < 1610; i++) begin
            rand_pixel();
            vsync_in = !(i < 1600);
            cycle();
            if (vsync_out === 1'b0) lowcnt++;
        end
        chk("vs_low_len", 16'(lowcnt), 16'd1600);

        // Blanking and out-of-range cells
        font[{vram[0], 4'd0}] = 8'hFF;
        x_px = 11'd3; y_px = 11'd0; activevideo_in = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        chk("blank_rgb", 16'(rgb), 16'd0);
        chk("blank_de", 16'(de_out), 16'd0);
        x_px = 11'd650; activevideo_in = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        chk("col80_rgb", 16'(rgb), 16'd0);
        x_px = 11'd40; y_px = 11'd485;
        for (int i = 0; i < 5; i++) cycle();
        chk("row30_de", 16'(de_out), 16'd0);

        // Cursor blink across 100 frames; one vsync fall already happened above
        fg_color = 3'b111; bg_color = 3'b001;
        cursor_en = 1'b1; cursor_col = 7'd3; cursor_row = 5'd2;
        frames = 1;
        for (int f = 0; f < 100; f++) begin
            vsync_in = 1'b0;
            cycle();
            vsync_in = 1'b1;
            frames++;
            x_px = 11'(24 + $urandom_range(0, 7));
            y_px = 11'(32 + $urandom_range(0, 15));
            activevideo_in = 1'b1;
            for (int i = 0; i < 5; i++) cycle();
            chk("blink_rgb", 16'(rgb), 16'(((frames % 64) >= 32) ? 3'b111 : 3'b001));
        end

        // Mid-frame asynchronous reset; frame counter is in its blink-on half here
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_idle("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) cycle();
        chk("post_rst_rgb", 16'(rgb), 16'(3'b001));
        chk("post_rst_de", 16'(de_out), 16'd1);

        for (int i = 0; i < 80; i++) begin
            rand_pixel();
            cursor_col = 7'($urandom_range(0, 90));
            cursor_row = 5'($urandom_range(0, 31));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
